fetch_buffer_stage: RTL and testbench
=====================================

Name: fetch_buffer_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Keeps the fetch PC, issues sequential reads to a fixed-latency instruction memory and queues returned words with their PCs in a prefetch FIFO.
- Presents one instruction per cycle to decode, whose opcode/funct3 fields drive the control decoder.
- Handles decode back-pressure (stall) and branch/jump redirects (flush).

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, >= 2.
- NOP_INSTR, 32'h0000_0013, word driven on instr_o when no valid instruction (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_mem_req_o  output  1  read request this cycle.
- instr_mem_addr_o  output  32  read address, word aligned.
- instr_mem_rdata_i  input  32  read data; valid exactly one cycle after an accepted request, no wait states.
- redirect_i  input  1  taken branch/jump; flush and refetch.
- redirect_pc_i  input  32  redirect target.
- stall_i  input  1  decode cannot accept this cycle.
- instr_o  output  32  instruction to decode.
- pc_o  output  32  PC of instr_o.
- valid_o  output  1  instr_o/pc_o hold a real instruction.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Reset values: fetch_pc=RESET_PC, FIFO empty (rd/wr ptr=0, count=0), inflight=0.
  - Outputs during reset: instr_mem_req_o=0, valid_o=0, instr_o=NOP_INSTR, pc_o=0.
  - A response arriving in the cycle after reset deasserts, for a pre-reset request, is discarded.
- Issue:
  - instr_mem_req_o = !reset && !redirect_i && (count + inflight < FIFO_DEPTH).
  - instr_mem_addr_o = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+4 (wraps mod 2^32), inflight <= 1, inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- Response: when inflight=1 and redirect_i=0, push {instr_mem_rdata_i, inflight_pc} into the FIFO at the clock edge.
  - The credit rule above guarantees a push never overflows.
- Output (combinational from FIFO head):
  - valid_o = (count>0) && !redirect_i.
  - instr_o = head instr if valid_o, else NOP_INSTR.
  - pc_o = head pc if valid_o, else 0.
  - Pop when valid_o && !stall_i.
  - Push and pop in the same cycle: count unchanged. Pointers wrap mod FIFO_DEPTH.
- Stall: holds head and outputs stable. Issue continues until count+inflight == FIFO_DEPTH; the in-flight response is still pushed.
- Redirect (cycle N):
  - Highest priority; overrides stall.
  - FIFO cleared (count=0, ptrs=0). In-flight response arriving in N is dropped. No issue in N.
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}; bits [1:0] are ignored.
  - N+1: request at target. N+2: data pushed. N+3: valid_o=1 with pc_o=target.
- Redirect on consecutive cycles: the last one wins; each cycle re-flushes.
- Latency from reset release (cycle 0):
  - Request for RESET_PC in cycle 0; push at end of cycle 1; valid_o=1 in cycle 2.
  - Steady state with no stall: one instruction per cycle, PCs strictly +4.
- No bypass from instr_mem_rdata_i to instr_o. No instruction is ever lost, duplicated or reordered except those discarded by redirect or reset.

Test Plan:
- Reset release, memory returns rdata=addr^32'hA5A5_0000, stall=0 -> issue addresses 0,4,8,... one per cycle; valid_o first high in cycle 2; pc_o sequence 0,4,8,... each with matching instr_o.
- stall_i held 10 cycles from cycle 4 (DEPTH=4) -> req drops once count+inflight=4; pc_o frozen at 0x8; after release pc_o 0x8,0xC,0x10,... consecutive, none skipped or repeated.
- With 3 FIFO entries and 1 in flight, redirect_i=1, redirect_pc_i=0x100 -> valid_o=0 that cycle; instr_mem_addr_o=0x100 next cycle; valid_o=1 with pc_o=0x100 three cycles after redirect; no pre-redirect PC ever appears.
- redirect_i and stall_i both high with full FIFO -> redirect wins: FIFO empty next cycle, fetch from target; later stall holds target instruction stable.
- redirect_pc_i=0x0000_0103 -> fetch address 0x0000_0100, pc_o 0x100.
- reset asserted one cycle while a request is in flight, with FIFO holding 2 entries -> after release, fetch restarts at RESET_PC, stale rdata not pushed, first valid pc_o = RESET_PC.

Source files
------------

// File: rtl/fetch_buffer_stage_if.sv
// Signal bundle between the fetch buffer stage, its instruction memory and the decoder.
// The master side is the fetch stage itself; the slave side is the surrounding pipeline.
interface fetch_buffer_stage_if;
    logic        instr_mem_req_o;
    logic [31:0] instr_mem_addr_o;
    logic [31:0] instr_mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;

    modport master (
        output instr_mem_req_o,
        output instr_mem_addr_o,
        input  instr_mem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  stall_i,
        output instr_o,
        output pc_o,
        output valid_o
    );

    modport slave (
        input  instr_mem_req_o,
        input  instr_mem_addr_o,
        output instr_mem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        output stall_i,
        input  instr_o,
        input  pc_o,
        input  valid_o
    );
endinterface

// File: rtl/fetch_buffer_stage.sv
// Instruction fetch stage: sequential PC, one-cycle-latency memory reads, prefetch FIFO
// feeding decode, with stall back-pressure and branch/jump redirect flushing.
module fetch_buffer_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input logic                   clk,
    input logic                   reset,
    fetch_buffer_stage_if.master  bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    ptr_t        r_rd_ptr;
    ptr_t        r_wr_ptr;
    cnt_t        r_count;
    logic [31:0] r_fifo_instr [FIFO_DEPTH];
    logic [31:0] r_fifo_pc    [FIFO_DEPTH];

    cnt_t        w_occupancy;
    logic        w_issue;
    logic        w_push;
    logic        w_valid;
    logic        w_pop;
    logic [31:0] w_redirect_pc;
    logic        w_unused_pc_bits;

    // Credit counts the in-flight read so its response always has a free slot.
    assign w_occupancy   = r_count + cnt_t'(r_inflight);
    assign w_issue       = !reset && !bus.redirect_i && (w_occupancy < DEPTH_C);
    assign w_push        = r_inflight && !bus.redirect_i;
    assign w_valid       = !reset && (r_count != '0) && !bus.redirect_i;
    assign w_pop         = w_valid && !bus.stall_i;
    assign w_redirect_pc = {bus.redirect_pc_i[31:2], 2'b00};

    assign w_unused_pc_bits = ^bus.redirect_pc_i[1:0];

    assign bus.instr_mem_req_o  = w_issue;
    assign bus.instr_mem_addr_o = r_fetch_pc;
    assign bus.valid_o          = w_valid;
    assign bus.instr_o          = w_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
    assign bus.pc_o             = w_valid ? r_fifo_pc[r_rd_ptr] : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (bus.redirect_i) begin
            // Flush wins over everything, including stall and the arriving response.
            r_fetch_pc    <= w_redirect_pc;
            r_inflight    <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.instr_mem_rdata_i;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        w_push |-> (r_count < DEPTH_C));

    a_pc_aligned: assert property (@(posedge clk) disable iff (reset)
        r_fetch_pc[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Directed bench for fetch_buffer_stage: a queue-level reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_fetch_buffer_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] KEY       = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic clk;
    logic reset;
    logic check_en;
    int   n_cmp;
    int   n_bad;

    fetch_buffer_stage_if bus ();

    fetch_buffer_stage #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: returns addr ^ KEY one cycle after an accepted request.
    logic [31:0] mem_addr = 32'h0;
    always @(posedge clk) begin
        if (bus.instr_mem_req_o) mem_addr <= bus.instr_mem_addr_o;
    end
    assign bus.instr_mem_rdata_i = mem_addr ^ KEY;

    // Reference model: what has been requested and what is waiting for decode.
    entry_t      m_q[$];
    logic        m_inflight = 1'b0;
    logic [31:0] m_inflight_pc = 32'h0;
    logic [31:0] m_fetch_pc = 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_inflight <= 1'b0;
            m_fetch_pc <= RESET_PC;
        end else if (bus.redirect_i) begin
            m_q.delete();
            m_inflight <= 1'b0;
            m_fetch_pc <= bus.redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            if ((m_q.size() + int'(m_inflight)) < DEPTH) begin
                m_inflight    <= 1'b1;
                m_inflight_pc <= m_fetch_pc;
                m_fetch_pc    <= m_fetch_pc + 32'd4;
            end else begin
                m_inflight <= 1'b0;
            end
            if (m_q.size() > 0 && !bus.stall_i) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(entry_t'{instr: m_inflight_pc ^ KEY, pc: m_inflight_pc});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            logic        exp_req;
            logic        exp_valid;
            exp_req   = !reset && !bus.redirect_i && ((m_q.size() + int'(m_inflight)) < DEPTH);
            exp_valid = !reset && (m_q.size() > 0) && !bus.redirect_i;
            check("model_req", 32'(bus.instr_mem_req_o), 32'(exp_req));
            if (exp_req) check("model_addr", bus.instr_mem_addr_o, m_fetch_pc);
            check("model_valid", 32'(bus.valid_o), 32'(exp_valid));
            check("model_instr", bus.instr_o, exp_valid ? m_q[0].instr : NOP_INSTR);
            check("model_pc", bus.pc_o, exp_valid ? m_q[0].pc : 32'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fail(input string name, input bit met);
        n_cmp++;
        if (!met) begin
            n_bad++;
            $display("FAIL %s: condition not reached within bound", name);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        check_en = 1'b0;
        reset = 1'b1;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.stall_i = 1'b0;

        cyc();
        check_en = 1'b1;
        #1;
        check("rst_req", 32'(bus.instr_mem_req_o), 32'h0);
        check("rst_valid", 32'(bus.valid_o), 32'h0);
        check("rst_instr", bus.instr_o, NOP_INSTR);
        check("rst_pc", bus.pc_o, 32'h0);

        // Reset release: cycle 0
        cyc(); reset = 1'b0; #1;
        check("c0_req", 32'(bus.instr_mem_req_o), 32'h1);
        check("c0_addr", bus.instr_mem_addr_o, 32'h0);
        check("c0_valid", 32'(bus.valid_o), 32'h0);
        cyc(); #1;
        check("c1_addr", bus.instr_mem_addr_o, 32'h4);
        check("c1_valid", 32'(bus.valid_o), 32'h0);
        cyc(); #1;
        check("c2_valid", 32'(bus.valid_o), 32'h1);
        check("c2_pc", bus.pc_o, 32'h0);
        check("c2_instr", bus.instr_o, 32'hA5A5_0000);
        cyc(); #1;
        check("c3_pc", bus.pc_o, 32'h4);
        check("c3_instr", bus.instr_o, 32'hA5A5_0004);

        // Stall cycles 4..13
        cyc(); bus.stall_i = 1'b1; #1;
        check("stall_c4_pc", bus.pc_o, 32'h8);
        repeat (9) cyc();
        #1;
        check("stall_c13_req", 32'(bus.instr_mem_req_o), 32'h0);
        check("stall_c13_pc", bus.pc_o, 32'h8);
        check("stall_c13_valid", 32'(bus.valid_o), 32'h1);
        cyc(); bus.stall_i = 1'b0; #1;
        check("rel_pc0", bus.pc_o, 32'h8);
        cyc(); #1;
        check("rel_pc1", bus.pc_o, 32'hC);
        cyc(); #1;
        check("rel_pc2", bus.pc_o, 32'h10);

        // Redirect with 3 entries and 1 in flight
        cyc(); bus.stall_i = 1'b1;
        for (int i = 0; i < 20 && !(m_q.size() == 3 && m_inflight); i++) cyc();
        wait_fail("wait_3_plus_1", m_q.size() == 3 && m_inflight);
        bus.stall_i = 1'b0;
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h100;
        #1;
        check("redir_n_valid", 32'(bus.valid_o), 32'h0);
        check("redir_n_req", 32'(bus.instr_mem_req_o), 32'h0);
        cyc(); bus.redirect_i = 1'b0; #1;
        check("redir_n1_req", 32'(bus.instr_mem_req_o), 32'h1);
        check("redir_n1_addr", bus.instr_mem_addr_o, 32'h100);
        check("redir_n1_valid", 32'(bus.valid_o), 32'h0);
        cyc(); #1;
        check("redir_n2_valid", 32'(bus.valid_o), 32'h0);
        cyc(); #1;
        check("redir_n3_valid", 32'(bus.valid_o), 32'h1);
        check("redir_n3_pc", bus.pc_o, 32'h100);
        check("redir_n3_instr", bus.instr_o, 32'hA5A5_0100);

        // Redirect and stall together with a full FIFO
        cyc(); bus.stall_i = 1'b1;
        for (int i = 0; i < 20 && m_q.size() != DEPTH; i++) cyc();
        wait_fail("wait_full", m_q.size() == DEPTH);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h200;
        #1;
        check("rs_n_valid", 32'(bus.valid_o), 32'h0);
        cyc(); bus.redirect_i = 1'b0; #1;
        check("rs_n1_valid", 32'(bus.valid_o), 32'h0);
        check("rs_n1_addr", bus.instr_mem_addr_o, 32'h200);
        cyc(); cyc(); #1;
        check("rs_n3_pc", bus.pc_o, 32'h200);
        check("rs_n3_instr", bus.instr_o, 32'hA5A5_0200);
        cyc(); cyc(); #1;
        check("rs_hold_pc", bus.pc_o, 32'h200);
        check("rs_hold_valid", 32'(bus.valid_o), 32'h1);
        bus.stall_i = 1'b0;

        // Unaligned redirect target
        cyc(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h103;
        cyc(); bus.redirect_i = 1'b0; #1;
        check("unal_addr", bus.instr_mem_addr_o, 32'h100);
        cyc(); cyc(); #1;
        check("unal_pc", bus.pc_o, 32'h100);

        // Back-to-back redirects: last one wins
        cyc(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h300;
        cyc(); bus.redirect_pc_i = 32'h400; #1;
        check("b2b_valid", 32'(bus.valid_o), 32'h0);
        check("b2b_req", 32'(bus.instr_mem_req_o), 32'h0);
        cyc(); bus.redirect_i = 1'b0; #1;
        check("b2b_addr", bus.instr_mem_addr_o, 32'h400);
        cyc(); cyc(); #1;
        check("b2b_pc", bus.pc_o, 32'h400);

        // PC wrap at 2^32
        cyc(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFF8;
        cyc(); bus.redirect_i = 1'b0; #1;
        check("wrap_addr0", bus.instr_mem_addr_o, 32'hFFFF_FFF8);
        cyc(); #1;
        check("wrap_addr1", bus.instr_mem_addr_o, 32'hFFFF_FFFC);
        cyc(); #1;
        check("wrap_addr2", bus.instr_mem_addr_o, 32'h0);
        check("wrap_pc0", bus.pc_o, 32'hFFFF_FFF8);
        cyc(); #1;
        check("wrap_pc1", bus.pc_o, 32'hFFFF_FFFC);
        cyc(); #1;
        check("wrap_pc2", bus.pc_o, 32'h0);

        // Reset with 2 entries queued and a read in flight
        cyc(); bus.stall_i = 1'b1;
        for (int i = 0; i < 20 && !(m_q.size() == 2 && m_inflight); i++) cyc();
        wait_fail("wait_2_plus_1", m_q.size() == 2 && m_inflight);
        reset = 1'b1;
        bus.stall_i = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.valid_o), 32'h0);
        check("mrst_req", 32'(bus.instr_mem_req_o), 32'h0);
        check("mrst_instr", bus.instr_o, NOP_INSTR);
        cyc(); reset = 1'b0; #1;
        check("mrst_c0_addr", bus.instr_mem_addr_o, RESET_PC);
        check("mrst_c0_valid", 32'(bus.valid_o), 32'h0);
        cyc(); #1;
        check("mrst_c1_valid", 32'(bus.valid_o), 32'h0);
        cyc(); #1;
        check("mrst_c2_valid", 32'(bus.valid_o), 32'h1);
        check("mrst_c2_pc", bus.pc_o, RESET_PC);
        check("mrst_c2_instr", bus.instr_o, RESET_PC ^ KEY);

        repeat (6) cyc();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
